// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared constants for the instruction fetch unit
// Purpose: FSM state encodings, NOP word, PC step and opcode width shared by
// inst_fetch_unit and pc_next_calc.
// Ports: none (package).
package inst_fetch_unit_pkg;

    localparam int OPCODE_WIDTH      = 7;
    localparam int FETCH_STATE_WIDTH = 2;
    localparam int PC_STEP           = 4;

    localparam logic [FETCH_STATE_WIDTH-1:0] S_IDLE = 2'd0;
    localparam logic [FETCH_STATE_WIDTH-1:0] S_REQ  = 2'd1;
    localparam logic [FETCH_STATE_WIDTH-1:0] S_WAIT = 2'd2;
    localparam logic [FETCH_STATE_WIDTH-1:0] S_HOLD = 2'd3;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-PC computation for fetch
// Purpose: selects branch target (inst_pc + imm) or sequential PC (inst_pc + 4),
// word-aligns the result and flags a target that had bit 1 set.
// Ports:
//   inst_pc      in  XLEN  address of the held instruction
//   imm          in  XLEN  sign-extended branch offset
//   take         in  1     branch taken (branch & alu_zero)
//   next_pc      out XLEN  word-aligned next fetch address
//   misalign_raw out 1     unaligned target bit (target[1])
module pc_next_calc
    import inst_fetch_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] inst_pc,
    input  logic [XLEN-1:0] imm,
    input  logic            take,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign_raw
);

    logic [XLEN-1:0] target;

    // Modular add: wraps at 2^XLEN silently.
    assign target       = take ? (inst_pc + imm) : (inst_pc + XLEN'(PC_STEP));
    assign next_pc      = target & ~XLEN'(3);
    assign misalign_raw = target[1];

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC owner and single-outstanding instruction fetcher
// Purpose: fetches one 32-bit instruction at a time over imem req/rvalid, holds it
// for decode under valid/ready, and advances the PC on accept (branch or +4).
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   imem_req/imem_addr                 one-cycle fetch request and address
//   imem_rvalid/imem_rdata             fetch response
//   inst_valid/inst_ready              decode handshake
//   inst/inst_pc/opcode                held instruction, its address, inst[6:0]
//   branch/alu_zero/imm                branch resolution, sampled on accept
//   flush/flush_pc                     redirect, highest priority
//   misalign                           one-cycle pulse: target bit 1 was set
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_rvalid,
    input  logic [31:0]             imem_rdata,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [31:0]             inst,
    output logic [XLEN-1:0]         inst_pc,
    output logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    branch,
    input  logic                    alu_zero,
    input  logic [XLEN-1:0]         imm,
    input  logic                    flush,
    input  logic [XLEN-1:0]         flush_pc,
    output logic                    misalign
);

    logic [FETCH_STATE_WIDTH-1:0] state;
    logic [XLEN-1:0]              pc;
    logic                         drop;
    logic [XLEN-1:0]              next_pc;
    logic                         misalign_raw;
    logic [XLEN-1:0]              flush_target;

    assign flush_target = flush_pc & ~XLEN'(3);
    assign opcode       = inst[OPCODE_WIDTH-1:0];

    pc_next_calc #(.XLEN(XLEN)) u_pc_next_calc (
        .inst_pc      (inst_pc),
        .imm          (imm),
        .take         (branch & alu_zero),
        .next_pc      (next_pc),
        .misalign_raw (misalign_raw)
    );

    // imem_req is loaded together with every transition into S_REQ so that it
    // is high for exactly the cycle spent in S_REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            inst_valid <= 1'b0;
            inst       <= INST_NOP;
            inst_pc    <= '0;
            misalign   <= 1'b0;
        end else begin
            imem_req <= 1'b0;
            misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    state     <= S_REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                S_REQ: begin
                    if (flush) begin
                        pc        <= flush_target;
                        imem_req  <= 1'b1;
                        imem_addr <= flush_target;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        pc <= flush_target;
                        if (imem_rvalid) begin
                            // Response arrives with the flush: discard it and
                            // refetch right away, nothing left outstanding.
                            drop      <= 1'b0;
                            state     <= S_REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= flush_target;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (drop) begin
                            drop      <= 1'b0;
                            state     <= S_REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                        end else begin
                            inst       <= imem_rdata;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (flush) begin
                        pc         <= flush_target;
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
                        imem_req   <= 1'b1;
                        imem_addr  <= flush_target;
                    end else if (inst_ready) begin
                        pc         <= next_pc;
                        inst_valid <= 1'b0;
                        misalign   <= misalign_raw;
                        state      <= S_REQ;
                        imem_req   <= 1'b1;
                        imem_addr  <= next_pc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
